// File: rtl/noc_pkg.sv
// Shared NoC definitions: queue depth, credit width, flit preamble layout
// and the transmit-side packet FSM state.
package noc;
  localparam int PortQueueDepth = 4;
  localparam int CreditsWidth   = $clog2(PortQueueDepth + 1);

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef enum logic {kTxIdle, kTxPacket} noc_tx_state_t;
endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one downstream queue: starts full, spends on dec,
// refunds on inc, saturates at Depth and flags a refund that would overflow.
module noc_credit_counter
  import noc::*;
#(
  parameter int Depth = PortQueueDepth,
  parameter int Width = CreditsWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] count,
  output logic             overflow
);

  // A refund with no simultaneous spend while already full is an overflow.
  assign overflow = inc & ~dec & (count == Width'(Depth));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= Width'(Depth);
    end else if (inc && !dec && !overflow) begin
      count <= count + Width'(1);
    end else if (dec && !inc) begin
      count <= count - Width'(1);
    end
  end

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-based NoC transmit port: checks head/tail framing, forwards legal
// flits with one cycle of latency and spends one downstream credit per flit.
module noc_credit_tx
  import noc::*;
#(
  parameter int FlitWidth = 64,
  parameter int Depth     = PortQueueDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FlitWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FlitWidth-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    credit_in,
  output logic [CreditsWidth-1:0] credits,
  output logic                    busy,
  output logic                    seq_err,
  output logic                    credit_err,
  output logic [15:0]             pkt_count
);

  noc_tx_state_t state;
  preamble_t     pre;
  logic          accept;
  logic          legal;
  logic          spend;
  logic          overflow;

  assign pre      = in_data[FlitWidth-1 -: 2];
  assign in_ready = (credits != '0);
  assign accept   = in_valid & in_ready;
  assign spend    = accept & legal;
  assign busy     = (state == kTxPacket);

  // Heads are only legal between packets; inside a packet only non-heads are.
  always_comb begin
    legal = 1'b0;
    case (state)
      kTxIdle:   legal = pre.head;
      kTxPacket: legal = ~pre.head;
      default:   legal = 1'b0;
    endcase
  end

  noc_credit_counter #(
    .Depth(Depth),
    .Width(CreditsWidth)
  ) u_credit_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (credit_in),
    .dec      (spend),
    .count    (credits),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= kTxIdle;
      out_data   <= '0;
      out_valid  <= 1'b0;
      seq_err    <= 1'b0;
      credit_err <= 1'b0;
      pkt_count  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (overflow) begin
        credit_err <= 1'b1;
      end
      if (accept) begin
        if (legal) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
          if (pre.tail) begin
            pkt_count <= pkt_count + 16'd1;
          end
          case (state)
            kTxIdle:   state <= pre.tail ? kTxIdle : kTxPacket;
            kTxPacket: state <= pre.tail ? kTxIdle : kTxPacket;
            default:   state <= kTxIdle;
          endcase
        end else begin
          // Illegal flits are consumed and dropped; framing state is untouched.
          seq_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed bench for noc_credit_tx: a vector table for the per-cycle
// behaviour plus hand sequences for async reset and credit-return waiting.
module tb_noc_credit_tx;

  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_data;
  logic          out_valid;
  logic          credit_in;
  logic [2:0]    credits;
  logic          busy;
  logic          seq_err;
  logic          credit_err;
  logic [15:0]   pkt_count;

  int checks   = 0;
  int failures = 0;

  noc_credit_tx #(.FlitWidth(FW), .Depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .credit_in  (credit_in),
    .credits    (credits),
    .busy       (busy),
    .seq_err    (seq_err),
    .credit_err (credit_err),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [1:0]  ht;
    logic [7:0]  pay;
    logic        ci;
    logic        ov;
    logic [9:0]  od;
    logic [2:0]  cr;
    logic        bsy;
    logic        se;
    logic        ce;
    logic [15:0] pk;
  } vec_t;

  vec_t vecs[30];

  function automatic logic [FW-1:0] flit(input logic [9:0] htp);
    return {htp[9:8], 54'b0, htp[7:0]};
  endfunction

  function automatic vec_t mkv(input logic r, input logic v, input logic [1:0] ht,
                               input logic [7:0] pay, input logic ci, input logic ov,
                               input logic [9:0] od, input logic [2:0] cr,
                               input logic bsy, input logic se, input logic ce,
                               input logic [15:0] pk);
    vec_t x;
    x.r = r; x.v = v; x.ht = ht; x.pay = pay; x.ci = ci;
    x.ov = ov; x.od = od; x.cr = cr; x.bsy = bsy; x.se = se; x.ce = ce; x.pk = pk;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [9:0] od,
                           input logic [2:0] cr, input logic bsy, input logic se,
                           input logic ce, input logic [15:0] pk);
    check({tag, "_out_valid"},  64'(out_valid),  64'(ov));
    check({tag, "_out_data"},   out_data,        flit(od));
    check({tag, "_credits"},    64'(credits),    64'(cr));
    check({tag, "_in_ready"},   64'(in_ready),   64'(cr != 3'd0));
    check({tag, "_busy"},       64'(busy),       64'(bsy));
    check({tag, "_seq_err"},    64'(seq_err),    64'(se));
    check({tag, "_credit_err"}, 64'(credit_err), 64'(ce));
    check({tag, "_pkt_count"},  64'(pkt_count),  64'(pk));
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] ht,
                       input logic [7:0] pay, input logic ci);
    rst       = r;
    in_valid  = v;
    in_data   = flit({ht, pay});
    credit_in = ci;
  endtask

  initial begin
    //                r  v  ht    pay    ci  | ov  od       cr   bsy se ce pk
    vecs[0]  = mkv(0, 1, 2'd3, 8'h01, 0,  1, 10'h301, 3'd3, 0, 0, 0, 16'd1);
    vecs[1]  = mkv(0, 1, 2'd3, 8'h02, 0,  1, 10'h302, 3'd2, 0, 0, 0, 16'd2);
    vecs[2]  = mkv(0, 1, 2'd3, 8'h03, 0,  1, 10'h303, 3'd1, 0, 0, 0, 16'd3);
    vecs[3]  = mkv(0, 1, 2'd3, 8'h04, 0,  1, 10'h304, 3'd0, 0, 0, 0, 16'd4);
    vecs[4]  = mkv(0, 1, 2'd3, 8'h05, 0,  0, 10'h304, 3'd0, 0, 0, 0, 16'd4);
    vecs[5]  = mkv(0, 1, 2'd3, 8'h05, 1,  0, 10'h304, 3'd1, 0, 0, 0, 16'd4);
    vecs[6]  = mkv(0, 1, 2'd3, 8'h05, 0,  1, 10'h305, 3'd0, 0, 0, 0, 16'd5);
    vecs[7]  = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h305, 3'd1, 0, 0, 0, 16'd5);
    vecs[8]  = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h305, 3'd2, 0, 0, 0, 16'd5);
    vecs[9]  = mkv(0, 1, 2'd3, 8'h06, 1,  1, 10'h306, 3'd2, 0, 0, 0, 16'd6);
    vecs[10] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h306, 3'd3, 0, 0, 0, 16'd6);
    vecs[11] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h306, 3'd4, 0, 0, 0, 16'd6);
    vecs[12] = mkv(0, 1, 2'd2, 8'h10, 0,  1, 10'h210, 3'd3, 1, 0, 0, 16'd6);
    vecs[13] = mkv(0, 1, 2'd0, 8'h11, 0,  1, 10'h011, 3'd2, 1, 0, 0, 16'd6);
    vecs[14] = mkv(0, 1, 2'd1, 8'h12, 0,  1, 10'h112, 3'd1, 0, 0, 0, 16'd7);
    vecs[15] = mkv(0, 1, 2'd0, 8'h13, 0,  0, 10'h112, 3'd1, 0, 1, 0, 16'd7);
    vecs[16] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h112, 3'd2, 0, 1, 0, 16'd7);
    vecs[17] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h112, 3'd3, 0, 1, 0, 16'd7);
    vecs[18] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h112, 3'd4, 0, 1, 0, 16'd7);
    vecs[19] = mkv(0, 1, 2'd2, 8'h20, 0,  1, 10'h220, 3'd3, 1, 1, 0, 16'd7);
    vecs[20] = mkv(0, 1, 2'd2, 8'h21, 0,  0, 10'h220, 3'd3, 1, 1, 0, 16'd7);
    vecs[21] = mkv(0, 1, 2'd3, 8'h22, 0,  0, 10'h220, 3'd3, 1, 1, 0, 16'd7);
    vecs[22] = mkv(0, 1, 2'd1, 8'h23, 0,  1, 10'h123, 3'd2, 0, 1, 0, 16'd8);
    vecs[23] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h123, 3'd3, 0, 1, 0, 16'd8);
    vecs[24] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h123, 3'd4, 0, 1, 0, 16'd8);
    vecs[25] = mkv(0, 0, 2'd0, 8'h00, 1,  0, 10'h123, 3'd4, 0, 1, 1, 16'd8);
    vecs[26] = mkv(0, 1, 2'd3, 8'h30, 1,  1, 10'h330, 3'd4, 0, 1, 1, 16'd9);
    vecs[27] = mkv(0, 1, 2'd2, 8'h31, 0,  1, 10'h231, 3'd3, 1, 1, 1, 16'd9);
    vecs[28] = mkv(1, 1, 2'd3, 8'h40, 1,  0, 10'h000, 3'd4, 0, 0, 0, 16'd0);
    vecs[29] = mkv(0, 0, 2'd0, 8'h00, 0,  0, 10'h000, 3'd4, 0, 0, 0, 16'd0);

    drive(1, 0, 2'd0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 10'h000, 3'd4, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, vecs[i].ht, vecs[i].pay, vecs[i].ci);
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].ov, vecs[i].od, vecs[i].cr,
                vecs[i].bsy, vecs[i].se, vecs[i].ce, vecs[i].pk);
    end

    // Asynchronous reset must take effect between clock edges.
    @(negedge clk);
    drive(0, 1, 2'd2, 8'h50, 0);
    @(posedge clk);
    #1;
    check("async_pre_busy", 64'(busy), 64'(1));
    check("async_pre_credits", 64'(credits), 64'(3));
    @(negedge clk);
    drive(1, 0, 2'd0, 8'h00, 0);
    #1;
    check_all("async_rst", 0, 10'h000, 3'd4, 0, 0, 0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Drain all credits, then hold a flit until a single credit returns.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 1, 2'd3, 8'h51 + 8'(k), 0);
    end
    @(negedge clk);
    drive(0, 1, 2'd3, 8'h60, 0);
    @(posedge clk);
    #1;
    check("drain_credits", 64'(credits), 64'(0));
    check("drain_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1'b1;
      end
      check("wait_out_valid", 64'(seen), 64'(1));
    end
    check("wait_out_data", out_data, flit(10'h360));
    check("wait_credits", 64'(credits), 64'(0));
    check("wait_pkt_count", 64'(pkt_count), 64'(5));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wait_single_pulse", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_credit_tx.md
NOC_CREDIT_TX -- requirements
Module: noc_credit_tx

Interface
REQ-001 SHALL have parameter FlitWidth, default 64, total flit width including preamble.
REQ-002 SHALL have parameter Depth, default noc::PortQueueDepth (4), downstream queue entries = initial credits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  FlitWidth  upstream flit; bit FlitWidth-1 = preamble head, bit FlitWidth-2 = preamble tail.
REQ-006 SHALL have port in_valid  input  1  upstream flit valid.
REQ-007 SHALL have port in_ready  output  1  module accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  FlitWidth  flit toward downstream router input queue.
REQ-009 SHALL have port out_valid  output  1  out_data valid; downstream writes it unconditionally.
REQ-010 SHALL have port credit_in  input  1  downstream freed one queue entry this cycle.
REQ-011 SHALL have port credits  output  noc::CreditsWidth  current credit count.
REQ-012 SHALL have port busy  output  1  high while in PACKET state.
REQ-013 SHALL have port seq_err  output  1  sticky: preamble sequence violation seen.
REQ-014 SHALL have port credit_err  output  1  sticky: credit_in received with credits == Depth.
REQ-015 SHALL have port pkt_count  output  16  tail flits sent, wraps 0xFFFF -> 0.

Function
REQ-016 SHALL assert in_ready combinationally iff registered credits != 0; no same-cycle credit_in bypass.
REQ-017 SHALL define accept = in_valid & in_ready; only accepted flits affect state.
REQ-018 SHALL, on a legal accepted flit, register it to out_data and assert out_valid the next cycle for exactly one cycle (latency 1).
REQ-019 SHALL hold out_data at last value when out_valid is low.
REQ-020 SHALL decrement credits on a legal accept, increment on credit_in, leave unchanged when both occur.
REQ-021 SHALL, on credit_in with credits == Depth and no legal accept, saturate at Depth and set credit_err.
REQ-022 SHALL implement FSM states IDLE and PACKET.
REQ-023 IDLE: head&tail flit -> forward, stay IDLE; head only -> forward, go PACKET; flit without head -> illegal.
REQ-024 PACKET: tail without head -> forward, go IDLE; neither -> forward, stay; any head flit -> illegal.
REQ-025 SHALL consume (accept) an illegal flit but drop it: no out_valid, no credit spent, state unchanged, seq_err set.
REQ-026 SHALL increment pkt_count when a legal flit with tail bit is forwarded.
REQ-027 seq_err and credit_err SHALL clear only on reset.

Reset
REQ-028 SHALL, on rst asserted (any cycle, including mid-packet), immediately set state IDLE, credits = Depth, out_valid 0, out_data 0, seq_err 0, credit_err 0, pkt_count 0.
REQ-029 SHALL drive busy 0 and in_ready 1 during and after reset until first accept.
REQ-030 SHALL ignore in_valid and credit_in while rst is high.

Structure
REQ-031 SHALL take Depth default, CreditsWidth and preamble_t from package noc; no new constants there except a tx FSM state enum noc_tx_state_t {kTxIdle, kTxPacket}.
REQ-032 SHALL place credit counter in sub-module noc_credit_counter (inc, dec, count, overflow flag); FSM and output register in top.

Verification
REQ-033 Reset then 4 single-flit packets (head=tail=1) back-to-back, no credit_in -> 4 out_valid pulses one cycle after each accept, credits 4->0, in_ready low on 5th cycle, pkt_count=4.
REQ-034 Credits=0, pulse credit_in once -> credits=1 next cycle, in_ready high, pending flit accepted, credits back to 0.
REQ-035 Credits=2, same cycle accept and credit_in -> credits stays 2, out_valid 1 next cycle.
REQ-036 3-flit packet head, body, tail -> busy high after head through tail, low after tail; then body flit in IDLE -> dropped, seq_err=1, credits unchanged.
REQ-037 Head flit then second head flit -> second dropped, seq_err=1, busy stays 1; following tail forwarded, busy 0.
REQ-038 Credits=4, credit_in -> credits 4, credit_err=1; assert rst mid-packet -> busy 0, credits 4, both errors 0.
